// File: rtl/div_tick_scheduler.sv
// div_tick_scheduler: round-robin owner of one shared modulo-N tick divider.
// Each grant delivers BURST ticks at the owner's ratio, then a done/err pulse.
module div_tick_scheduler #(
    parameter int NREQ  = 4,
    parameter int DW    = 4,
    parameter int BURST = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] ratio,
    output logic [NREQ-1:0]    gnt,
    output logic               tick,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(BURST) + 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
    localparam logic [TW-1:0] TLAST = TW'(BURST - 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          sel_vld;
    logic [DW-1:0] n;
    logic [DW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] rat [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_rat
        assign rat[i] = ratio[i*DW +: DW];
    end

    // nearest requester after ptr, wrapping; later hits override so i=1 wins
    always_comb begin
        sel     = '0;
        idx     = '0;
        sel_vld = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    // tick fires on the last enabled cycle of each N-cycle period
    assign tick = (state == RUN) && en && req[g] && (cnt == n - 1'b1);

    assign busy = (state != IDLE);

    // grant/burst sequencer; done and err are one-cycle pulses into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            err   <= '0;
            cnt   <= '0;
            tcnt  <= '0;
            ptr   <= PTR_RST;
            g     <= '0;
            n     <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            unique case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gnt   <= ONE << sel;
                        ptr   <= sel;
                        g     <= sel;
                        n     <= rat[sel];
                        cnt   <= '0;
                        tcnt  <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (n == '0) begin
                        gnt   <= '0;
                        err   <= gnt;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!req[g]) begin
                        gnt   <= '0;
                        state <= IDLE;
                    end else if (en) begin
                        if (tick) begin
                            cnt  <= '0;
                            tcnt <= tcnt + 1'b1;
                            if (tcnt == TLAST) begin
                                gnt   <= '0;
                                done  <= gnt;
                                state <= DONE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_tick_scheduler.md
# div_tick_scheduler

Round-robin scheduler that shares one programmable modulo-N tick counter among NREQ requesters. Each requester supplies its own divide ratio. A granted requester receives a burst of BURST ticks, one every N enabled clock cycles, followed by a one-cycle done pulse. The block sits above the divide-by-N counter stage and sequences it, so several consumers can use a single divider without each instantiating its own.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- DW, 4, width of each ratio field
- BURST, 3, ticks delivered per grant (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global count enable; low freezes the counter and the burst counter in RUN
- req  in  NREQ  level request, one bit per requester
- ratio  in  NREQ*DW  packed divide ratios; requester i uses bits [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, registered
- tick  out  1  one-cycle tick to the granted requester
- done  out  NREQ  one-cycle pulse when a burst completes, registered
- err  out  NREQ  one-cycle pulse when a grant is refused because the latched ratio is 0, registered
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE → LOAD → RUN → DONE → IDLE.
  - LOAD → DONE directly on a zero ratio.
  - RUN → IDLE on abort.
- Reset values: state=IDLE, gnt=0, done=0, err=0, tick=0, busy=0, cnt=0, tcnt=0, ptr=NREQ-1 (requester 0 has highest priority after reset).
- **IDLE**: if any req bit is high, select the first set bit searching ptr+1, ptr+2, … with wrap modulo NREQ. Next edge: gnt=onehot(g), ptr=g, N=ratio[g], cnt=0, tcnt=0, state=LOAD.
- **LOAD** (one cycle):
  - N==0 → DONE with the error flag set.
  - Otherwise → RUN.
- **RUN**: tick is combinational and equals (state==RUN && en && req[g] && cnt==N-1).
  - en low: nothing changes.
  - Otherwise cnt increments. On a tick, cnt→0 and tcnt increments.
  - A tick with tcnt==BURST-1 → DONE.
  - N==1: a tick occurs on every enabled cycle.
- **Abort**: if req[g] drops during RUN, the next edge goes to IDLE with gnt=0. No tick is produced in that cycle, and no done or err pulse is issued. ptr still advances to g.
- **DONE** (one cycle):
  - gnt=0.
  - done[g]=1 if the error flag is clear; otherwise err[g]=1.
  - Next edge → IDLE.
- A requester must see done or err before the scheduler can re-grant it. Requests are re-arbitrated only in IDLE.
- Counter width is DW. cnt never exceeds N-1. tcnt width is clog2(BURST)+1.

## Timing
- Request-to-grant latency: request seen in IDLE at edge k → gnt high after edge k+1 (LOAD).
- RUN is entered at edge k+2. The first tick is in the N-th enabled cycle of RUN; subsequent ticks follow every N enabled cycles.
- Grant duration with en held high: 1 (LOAD) + N·BURST (RUN) cycles. DONE follows for one cycle. IDLE lasts at least one cycle before the next grant.
- With en high throughout, minimum request-to-done latency is 2 + N·BURST edges.
- Simultaneous requests: only one is granted per IDLE visit. Winners follow round-robin order from ptr.
- Changes to ratio[g] after LOAD are ignored. Changes to ratio for non-granted requesters have no effect.
- rst asserted in any state: every output is at its reset value after that edge, an in-flight burst is discarded, and no done is issued.
- en low in IDLE, LOAD or DONE has no effect; only RUN is frozen.

## Test plan
- **Single request**: req=0001, ratio0=3, BURST=3, en=1.
  - gnt=0001 one cycle after the request.
  - Ticks 3 cycles apart, 3 ticks total.
  - done=0001 for exactly one cycle; busy falls after DONE.
- **Round-robin**: req=1111, ratios 1/2/3/4.
  - Grant order 0,1,2,3,0.
  - Tick spacing per grant is 1, 2, 3, 4 cycles.
  - Exactly one gnt bit is high at any time.
- **Zero ratio**: req=0100, ratio2=0.
  - gnt=0100 for one cycle, then err=0100 for one cycle.
  - No tick, no done.
- **en gating**: ratio0=2; drop en for 5 cycles mid-RUN.
  - No tick while en is low and cnt/tcnt are held.
  - Total ticks still 3; done is delayed by exactly 5 cycles.
- **Abort**: req=0011, ratio=4; drop req0 after its first tick.
  - Next edge: gnt=0, no done[0].
  - Then gnt=0010 and requester 1 completes a full burst.
- **Reset mid-burst**: assert rst during RUN for one cycle.
  - All outputs 0 on the next edge.
  - With req=1000 afterwards, requester 0 retains priority and the grant goes to 3 only when req0 is low.
